serial_adder: RTL and testbench

- Bit-serial multi-bit adder that drives the existing combinational `fulladder` one bit per clock, LSB first.
- A registered carry flip-flop closes the carry loop between bits.
- It sits directly upstream of `fulladder`: it sequences operands into the cell and collects `sum`/`cout` into a word result.
- It gives the datapath an area-minimal WIDTH-bit adder with a start/done handshake.

---
 rtl/serial_adder_pkg.sv | 17 +
 rtl/fulladder.sv | 15 +
 rtl/serial_adder.sv | 125 ++++++++++++
 tb/tb_serial_adder.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
//   state_e   : controller state encoding (idle / shifting / result pulse)
//   cnt_width : bit-counter width for a given operand width
package serial_adder_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  // Width of a counter that indexes bits 0..w-1; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/fulladder.sv
// Combinational one-bit full adder cell.
//   a, b, cin : addend bits and carry-in
//   sum, cout : sum bit and carry-out
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder built around a single fulladder cell, LSB first.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request, accepted when not busy (also accepted in the done cycle)
//   a, b, cin  : operands and carry-in, latched on the accepting edge
//   busy       : high while bits are being processed
//   done       : one-cycle pulse when sum/cout/ovf hold a new result
//   sum, cout  : result word and carry out of the MSB, held until next completion
//   ovf        : signed overflow, held with sum
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   part_q, part_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic fa_sum;
  logic fa_cout;

  fulladder u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    part_d  = part_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StShift;
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          part_d  = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StShift: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        // Sum bits enter at the MSB so bit 0 lands at position 0 after WIDTH shifts.
        part_d  = {fa_sum, part_q[WIDTH-1:1]};
        carry_d = fa_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LastCnt) begin
          state_d = StDone;
          cnt_d   = '0;
          sum_d   = {fa_sum, part_q[WIDTH-1:1]};
          cout_d  = fa_cout;
          // carry_q is the carry into the MSB for this last bit.
          ovf_d   = carry_q ^ fa_cout;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      part_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      part_q  <= part_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == StShift);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed corner cases plus
// randomized operations checked against plain integer arithmetic.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int n_checks;
  int n_pass;

  logic [W-1:0] prev_sum;
  logic         prev_cout;
  logic         prev_ovf;

  serial_adder #(
    .WIDTH (W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  // Advance one rising edge and sample 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation, scramble inputs while busy, and check timing and result.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                        input string tag);
    logic [W:0] exp_full;
    int         s;
    logic       exp_ovf;
    int         edges;
    int         busy_cnt;
    bit         seen;
    exp_full = {1'b0, av} + {1'b0, bv} + (W+1)'(cv);
    s        = int'($signed(av)) + int'($signed(bv)) + int'(cv);
    exp_ovf  = (s > (2 ** (W - 1)) - 1) || (s < -(2 ** (W - 1)));
    a = av; b = bv; cin = cv; start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, ":held"}, {prev_ovf, prev_cout, sum}, {ovf, cout, prev_sum} & 0 | {prev_ovf, prev_cout, prev_sum});
    edges = 0; busy_cnt = 0; seen = 1'b0;
    while (!seen && edges < 4 * W) begin
      if (busy) busy_cnt++;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom); start = 1'($urandom);
      tick();
      edges++;
      seen = done;
    end
    start = 1'b0;
    check({tag, ":lat"}, edges, W);
    check({tag, ":busy"}, busy_cnt, W);
    check({tag, ":sum"}, sum, exp_full[W-1:0]);
    check({tag, ":cout"}, cout, exp_full[W]);
    check({tag, ":ovf"}, ovf, exp_ovf);
    prev_sum = exp_full[W-1:0]; prev_cout = exp_full[W]; prev_ovf = exp_ovf;
  endtask

  initial begin
    int dn[$];
    int pulses;
    logic [W-1:0] cap;
    n_checks = 0; n_pass = 0;
    start = 1'b0; a = '0; b = '0; cin = 1'b0;
    prev_sum = '0; prev_cout = 1'b0; prev_ovf = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst:busy", busy, 0);
    check("rst:done", done, 0);
    check("rst:res", {ovf, cout, sum}, 0);
    rst_n = 1'b1;
    tick();

    run_op(8'h00, 8'h00, 1'b0, "zero");
    run_op(8'hFF, 8'h01, 1'b0, "wrap");
    run_op(8'h7F, 8'h01, 1'b0, "sovf1");
    run_op(8'h80, 8'h80, 1'b0, "sovf2");
    run_op(8'hA5, 8'h5A, 1'b1, "cin1");
    run_op(8'h12, 8'h34, 1'b1, "cin2");
    tick();

    // Re-pulse of start while busy must be ignored.
    a = 8'h03; b = 8'h04; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    a = 8'hFF; start = 1'b1;
    tick();
    start = 1'b0; a = '0; b = '0;
    pulses = 0; cap = '0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (done) begin pulses++; cap = sum; end
    end
    check("ign:pulses", pulses, 1);
    check("ign:sum", cap, 8'h07);
    prev_sum = 8'h07; prev_cout = 1'b0; prev_ovf = 1'b0;

    // Start held high: back-to-back ops, one done every W+1 cycles.
    a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
    for (int i = 1; i <= 40 && dn.size() < 3; i++) begin
      tick();
      if (done) begin
        dn.push_back(i);
        check("b2b:sum", sum, 8'h33);
      end
    end
    start = 1'b0;
    check("b2b:count", dn.size(), 3);
    if (dn.size() == 3) begin
      check("b2b:gap1", dn[1] - dn[0], W + 1);
      check("b2b:gap2", dn[2] - dn[1], W + 1);
    end
    tick();
    prev_sum = 8'h33; prev_cout = 1'b0; prev_ovf = 1'b0;

    // Asynchronous reset in the middle of an operation.
    a = 8'h55; b = 8'h11; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst:busy", busy, 0);
    check("arst:done", done, 0);
    check("arst:res", {ovf, cout, sum}, 0);
    tick();
    check("arst:hold", {busy, done}, 0);
    #2 rst_n = 1'b1;
    prev_sum = '0; prev_cout = 1'b0; prev_ovf = 1'b0;
    tick();
    run_op(8'h10, 8'h20, 1'b0, "post_rst");

    // Randomized regression with 0-3 idle cycles between operations.
    for (int n = 0; n < 1000; n++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) tick();
      run_op(W'($urandom), W'($urandom), 1'($urandom), "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1);
  end

endmodule
